// File: rtl/ref_mem_loader_if.sv
// rtl/ref_mem_loader_if.sv - row-segment stream from the fetch path into the loader
interface ref_mem_loader_if #(
    parameter int PIXEL = 8
);
    logic [32*PIXEL-1:0] in_data;
    logic                in_valid;
    logic                in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ref_mem_loader.sv
// rtl/ref_mem_loader.sv - write-side controller filling the 32-bank reference window memory
module ref_mem_loader #(
    parameter int PIXEL    = 8,
    parameter int ROWS     = 96,
    parameter int COLS_BLK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           col_start,
    input  logic [7:0]           col_num,
    ref_mem_loader_if.slave      s,
    output logic [32*PIXEL-1:0]  ref_input,
    output logic [31:0]          Bank_sel,
    output logic [7*32-1:0]      write_address_all,
    output logic                 busy,
    output logic                 ld_done
);
    localparam int             RW        = $clog2(ROWS);
    localparam logic [RW-1:0]  ROW_LAST  = RW'(ROWS - 1);
    localparam logic [7:0]     COLS_BLK8 = 8'(COLS_BLK);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t         state;
    logic [RW-1:0]  row;
    logic [7:0]     blk_idx;
    logic [7:0]     blk_num;
    logic [7:0]     col;
    logic [6:0]     wr_addr;
    logic [7:0]     num_sat;
    logic [6:0]     beat_addr;

    assign num_sat   = (col_num > COLS_BLK8) ? COLS_BLK8 : col_num;
    // Each group of 32 rows occupies one address slot per column block.
    assign beat_addr = 7'((32'(row) >> 5) * COLS_BLK + 32'(col));
    assign write_address_all = {32{wr_addr}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            blk_idx    <= '0;
            blk_num    <= '0;
            col        <= '0;
            wr_addr    <= '0;
            ref_input  <= '0;
            Bank_sel   <= '0;
            s.in_ready <= 1'b0;
            busy       <= 1'b0;
            ld_done    <= 1'b0;
        end else begin
            Bank_sel <= '0;
            ld_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        col     <= col_start % COLS_BLK8;
                        blk_num <= num_sat;
                        row     <= '0;
                        blk_idx <= '0;
                        busy    <= 1'b1;
                        if (num_sat == 8'd0) begin
                            state   <= DONE;
                            ld_done <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            s.in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (s.in_valid) begin
                        Bank_sel  <= 32'(1) << row[4:0];
                        ref_input <= s.in_data;
                        wr_addr   <= beat_addr;
                        if (row == ROW_LAST) begin
                            row <= '0;
                            if (blk_idx == blk_num - 8'd1) begin
                                state      <= DONE;
                                s.in_ready <= 1'b0;
                                ld_done    <= 1'b1;
                            end else begin
                                blk_idx <= blk_idx + 8'd1;
                                col     <= (col == COLS_BLK8 - 8'd1) ? 8'd0 : col + 8'd1;
                            end
                        end else begin
                            row <= row + RW'(1);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ref_mem_loader.sv
// tb/tb_ref_mem_loader.sv - randomized scoreboard bench for ref_mem_loader
module tb_ref_mem_loader;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   col_start;
    logic [7:0]   col_num;
    logic [255:0] ref_input;
    logic [31:0]  Bank_sel;
    logic [223:0] write_address_all;
    logic         busy;
    logic         ld_done;

    ref_mem_loader_if #(.PIXEL(8)) s ();

    ref_mem_loader #(.PIXEL(8), .ROWS(96), .COLS_BLK(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .col_start         (col_start),
        .col_num           (col_num),
        .s                 (s),
        .ref_input         (ref_input),
        .Bank_sel          (Bank_sel),
        .write_address_all (write_address_all),
        .busy              (busy),
        .ld_done           (ld_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   bank;
        logic [6:0]   addr;
        logic [255:0] data;
    } exp_t;

    exp_t        q[$];
    logic [11:0] wlog[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          writes = 0;
    int          dones = 0;
    int          cur_n = 0;
    logic        mon_en = 1'b0;
    logic        prev_acc = 1'b0;

    task automatic chk(input string nm, input logic ok, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", nm, act, req);
    endtask

    function automatic logic [4:0] onehot_idx(input logic [31:0] v);
        logic [4:0] idx = '0;
        for (int b = 0; b < 32; b++) if (v[b]) idx = 5'(b);
        return idx;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_acc) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 1'b0, 256'(Bank_sel), 256'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("bank_sel", Bank_sel == (32'(1) << e.bank), 256'(Bank_sel), 256'(32'(1) << e.bank));
                    chk("wr_addr", write_address_all == {32{e.addr}}, 256'(write_address_all), 256'({32{e.addr}}));
                    chk("ref_input", ref_input == e.data, ref_input, e.data);
                end
                writes++;
                wlog.push_back({onehot_idx(Bank_sel), write_address_all[6:0]});
            end else begin
                chk("bank_sel_idle", Bank_sel == 32'd0, 256'(Bank_sel), 256'd0);
            end
            if (ld_done) begin
                dones++;
                chk("done_queue_empty", q.size() == 0, 256'(q.size()), 256'd0);
                chk("done_with_last_write", (Bank_sel != 0) == (cur_n != 0), 256'(Bank_sel), 256'(cur_n != 0));
            end
        end
        prev_acc = s.in_valid && s.in_ready && !rst;
    end

    task automatic do_load(input int cs, input int cn, input int duty,
                           input int sa, input int sb, input int abort_at);
        int           n;
        int           b;
        logic [255:0] d;
        exp_t         e;
        n = ((cn > 4) ? 4 : cn) * 96;
        cur_n = n;
        writes = 0;
        dones = 0;
        wlog.delete();
        @(posedge clk); #1;
        start = 1'b1; col_start = 8'(cs); col_num = 8'(cn);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy == 1'b1, 256'(busy), 256'd1);
        chk("start_in_ready", s.in_ready == (n != 0), 256'(s.in_ready), 256'(n != 0));
        chk("start_ld_done", ld_done == (n == 0), 256'(ld_done), 256'(n == 0));
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                rst = 1'b1; s.in_valid = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0; s.in_valid = 1'b0;
                @(negedge clk);
                chk("rst_bank_sel", Bank_sel == 32'd0, 256'(Bank_sel), 256'd0);
                chk("rst_outputs", {ref_input, write_address_all} == '0, ref_input, 256'd0);
                chk("rst_flags", {s.in_ready, busy, ld_done} == 3'b000, 256'({s.in_ready, busy, ld_done}), 256'd0);
                return;
            end
            while ($urandom_range(99) >= duty) begin
                @(posedge clk); #1;
            end
            d = {8{$urandom}};
            s.in_valid = 1'b1;
            s.in_data = d;
            start = (k == sa || k == sb);
            b = 0;
            @(negedge clk);
            while (!s.in_ready && b < 8) begin
                @(negedge clk);
                b++;
            end
            if (!s.in_ready) chk("beat_accept_timeout", 1'b0, 256'(k), 256'd1);
            e.bank = 5'((k % 96) % 32);
            e.addr = 7'(((k % 96) / 32) * 4 + ((cs % 4) + k / 96) % 4);
            e.data = d;
            q.push_back(e);
            @(posedge clk); #1;
            s.in_valid = 1'b0;
            start = 1'b0;
        end
        if (n != 0) begin
            @(negedge clk);
            chk("last_in_ready", s.in_ready == 1'b0, 256'(s.in_ready), 256'd0);
            chk("last_ld_done", ld_done == 1'b1, 256'(ld_done), 256'd1);
            chk("last_busy", busy == 1'b1, 256'(busy), 256'd1);
        end
        @(negedge clk);
        chk("busy_drop", busy == 1'b0, 256'(busy), 256'd0);
        repeat (3) @(negedge clk);
        chk("write_count", writes == n, 256'(writes), 256'(n));
        chk("done_count", dones == 1, 256'(dones), 256'd1);
        chk("queue_drained", q.size() == 0, 256'(q.size()), 256'd0);
    endtask

    task automatic chk_log(input string nm, input int idx, input int bank, input int addr);
        logic [11:0] req;
        req = {5'(bank), 7'(addr)};
        if (idx < wlog.size()) chk(nm, wlog[idx] == req, 256'(wlog[idx]), 256'(req));
        else chk(nm, 1'b0, 256'(wlog.size()), 256'(idx));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; col_start = '0; col_num = '0;
        s.in_valid = 1'b0; s.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bank_sel", Bank_sel == 32'd0, 256'(Bank_sel), 256'd0);
        chk("reset_outputs", {ref_input, write_address_all} == '0, ref_input, 256'd0);
        chk("reset_flags", {s.in_ready, busy, ld_done} == 3'b000, 256'({s.in_ready, busy, ld_done}), 256'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        do_load(0, 4, 100, -1, -1, -1);
        chk_log("full_b0", 0, 0, 0);
        chk_log("full_b33", 33, 1, 4);
        chk_log("full_b95", 95, 31, 8);
        chk_log("full_b96", 96, 0, 1);
        chk_log("full_b383", 383, 31, 11);

        do_load(3, 2, 100, -1, -1, -1);
        chk_log("wrap_b0", 0, 0, 3);
        chk_log("wrap_b40", 40, 8, 7);
        chk_log("wrap_b95", 95, 31, 11);
        chk_log("wrap_b96", 96, 0, 0);
        chk_log("wrap_b191", 191, 31, 8);

        do_load(0, 4, 30, -1, -1, -1);
        chk_log("bp_b33", 33, 1, 4);
        chk_log("bp_b383", 383, 31, 11);

        do_load(1, 4, 80, 10, 200, -1);
        chk_log("start_ign_b200", 200, 8, 3);

        do_load(0, 4, 100, -1, -1, 51);
        repeat (3) @(negedge clk);
        chk("abort_writes", writes == 51, 256'(writes), 256'd51);
        chk("abort_no_done", dones == 0, 256'(dones), 256'd0);
        chk("abort_queue", q.size() == 0, 256'(q.size()), 256'd0);
        do_load(0, 4, 100, -1, -1, -1);
        chk_log("restart_b0", 0, 0, 0);

        do_load(2, 0, 100, -1, -1, -1);
        do_load(0, 9, 60, -1, -1, -1);
        chk_log("sat_b383", 383, 31, 11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
